// File: rtl/swap_pkg.sv
// Shared constants for the swap_unit operand-exchange stage.
// Mode encodings match the ALU front-end decode table.
package swap_pkg;

   localparam int SWAP_WIDTH = 16;

   typedef enum logic [1:0] {
      MODE_SWAP  = 2'b00,
      MODE_PASS  = 2'b01,
      MODE_SORT  = 2'b10,
      MODE_SWAP2 = 2'b11
   } mode_e;

endpackage

// File: rtl/swap_cmp.sv
// Unsigned greater-than comparator feeding the compare-swap mode of swap_unit.
// Purely combinational; present only when SWAP_SORT_EN is defined.
`ifdef SWAP_SORT_EN
module swap_cmp #(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             aGtB
);

   assign aGtB = (a > b);

endmodule
`endif

// File: rtl/swap_unit.sv
// Registered operand exchange: swap / pass / compare-swap (SWAP_SORT_EN), 1-cycle latency.
// No backpressure: one pair per cycle; without SWAP_SORT_EN mode 10 swaps unconditionally.
module swap_unit
   import swap_pkg::*;
#(
   parameter int WIDTH = SWAP_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] operandA,
   input  logic [WIDTH-1:0] operandB,
   output logic [WIDTH-1:0] A,
   output logic [WIDTH-1:0] B,
   output logic             out_valid,
   output logic             swapped
);

   logic doSwap;

`ifdef SWAP_SORT_EN
   logic aGtB;

   swap_cmp #(.WIDTH(WIDTH)) uCmp (
      .a    (operandA),
      .b    (operandB),
      .aGtB (aGtB)
   );
`endif

   always_comb begin
      doSwap = 1'b1;
      case (mode_e'(mode))
         MODE_PASS: doSwap = 1'b0;
`ifdef SWAP_SORT_EN
         // Equal operands pass straight so swapped reflects a real reorder.
         MODE_SORT: doSwap = aGtB;
`endif
         default:   doSwap = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         A         <= '0;
         B         <= '0;
         out_valid <= 1'b0;
         swapped   <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            A       <= doSwap ? operandB : operandA;
            B       <= doSwap ? operandA : operandB;
            swapped <= doSwap;
         end
      end
   end

endmodule

// File: tb/tb_swap_unit.sv
// Directed-vector bench for swap_unit: driver queues hand-computed results,
// a monitor compares them against the registered outputs every cycle.
module tb_swap_unit;

   typedef struct {
      logic        rst;
      logic        vld;
      logic [1:0]  mode;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] expA;
      logic [15:0] expB;
      logic        expV;
      logic        expS;
   } vec_t;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        v;
      logic        s;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [1:0]  mode;
   logic [15:0] operandA;
   logic [15:0] operandB;
   logic [15:0] A;
   logic [15:0] B;
   logic        out_valid;
   logic        swapped;

   vec_t vecs[$];
   exp_t expQ[$];
   int   vectors = 0;
   int   miscompares = 0;

   swap_unit #(.WIDTH(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .mode      (mode),
      .operandA  (operandA),
      .operandB  (operandB),
      .A         (A),
      .B         (B),
      .out_valid (out_valid),
      .swapped   (swapped)
   );

   always #5 clk = ~clk;

   task automatic addVec(input logic r, input logic v, input logic [1:0] m,
                         input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] ea, input logic [15:0] eb,
                         input logic ev, input logic es);
      vec_t t;
      t.rst = r; t.vld = v; t.mode = m; t.a = a; t.b = b;
      t.expA = ea; t.expB = eb; t.expV = ev; t.expS = es;
      vecs.push_back(t);
   endtask

   // Monitor: one expected record per driven edge, checked just after that edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (expQ.size() != 0) begin
            e = expQ.pop_front();
            vectors++;
            if (A !== e.a || B !== e.b || out_valid !== e.v || swapped !== e.s) begin
               miscompares++;
               $display("FAIL vec%0d: got A=%h B=%h out_valid=%b swapped=%b, want A=%h B=%h out_valid=%b swapped=%b",
                        vectors, A, B, out_valid, swapped, e.a, e.b, e.v, e.s);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      exp_t e;
      int   waitCycles;
      rst = 1'b1; in_valid = 1'b0; mode = 2'b00; operandA = '0; operandB = '0;

      // reset, two edges
      addVec(1, 0, 2'b00, 16'd0,      16'd0,      16'h0000, 16'h0000, 0, 0);
      addVec(1, 0, 2'b00, 16'd0,      16'd0,      16'h0000, 16'h0000, 0, 0);
      // swap 99/64, held for several cycles
      for (int i = 0; i < 6; i++)
         addVec(0, 1, 2'b00, 16'd99, 16'd64, 16'd64, 16'd99, 1, 1);
      // pass-through
      addVec(0, 1, 2'b01, 16'h1234,   16'hABCD,   16'h1234, 16'hABCD, 1, 0);
      // mode 10: greater-first pair swaps in both builds
      addVec(0, 1, 2'b10, 16'd99,     16'd64,     16'd64,   16'd99,   1, 1);
`ifdef SWAP_SORT_EN
      addVec(0, 1, 2'b10, 16'd64,     16'd99,     16'd64,   16'd99,   1, 0);
      addVec(0, 1, 2'b10, 16'd7,      16'd7,      16'd7,    16'd7,    1, 0);
`else
      addVec(0, 1, 2'b10, 16'd64,     16'd99,     16'd99,   16'd64,   1, 1);
      addVec(0, 1, 2'b10, 16'd7,      16'd7,      16'd7,    16'd7,    1, 1);
`endif
      // accepted pair then idle: outputs hold, valid drops
      addVec(0, 1, 2'b00, 16'd5,      16'd9,      16'd9,    16'd5,    1, 1);
      addVec(0, 0, 2'b01, 16'd1,      16'd2,      16'd9,    16'd5,    0, 1);
      addVec(0, 0, 2'b01, 16'd3,      16'd4,      16'd9,    16'd5,    0, 1);
      // pass then idle: swapped=0 held
      addVec(0, 1, 2'b01, 16'd11,     16'd22,     16'd11,   16'd22,   1, 0);
      addVec(0, 0, 2'b00, 16'd33,     16'd44,     16'd11,   16'd22,   0, 0);
      // reset wins over a valid pair
      addVec(1, 1, 2'b00, 16'd99,     16'd64,     16'h0000, 16'h0000, 0, 0);
      // extremes in mode 10, then mode 11
      addVec(0, 1, 2'b10, 16'hFFFF,   16'h0000,   16'h0000, 16'hFFFF, 1, 1);
      addVec(0, 1, 2'b11, 16'd1,      16'd2,      16'd2,    16'd1,    1, 1);
      // reset mid-stream, then first valid after reset
      addVec(1, 1, 2'b01, 16'hBEEF,   16'hCAFE,   16'h0000, 16'h0000, 0, 0);
      addVec(0, 1, 2'b01, 16'hBEEF,   16'hCAFE,   16'hBEEF, 16'hCAFE, 1, 0);
      addVec(0, 1, 2'b10, 16'h8000,   16'h7FFF,   16'h7FFF, 16'h8000, 1, 1);

      foreach (vecs[i]) begin
         @(negedge clk);
         rst      = vecs[i].rst;
         in_valid = vecs[i].vld;
         mode     = vecs[i].mode;
         operandA = vecs[i].a;
         operandB = vecs[i].b;
         e.a = vecs[i].expA; e.b = vecs[i].expB;
         e.v = vecs[i].expV; e.s = vecs[i].expS;
         expQ.push_back(e);
      end
      @(negedge clk);
      in_valid = 1'b0;

      waitCycles = 0;
      while (expQ.size() != 0 && waitCycles < 10) begin
         @(negedge clk);
         waitCycles++;
      end
      if (expQ.size() != 0) begin
         miscompares++;
         $display("FAIL drain: %0d expected results never checked, want 0", expQ.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
